midi_packet_assembler: RTL and testbench

MIDI_PACKET_ASSEMBLER -- requirements
Module: midi_packet_assembler

---
 rtl/midi_packet_assembler.sv | 180 ++++++++++++++++++
 tb/tb_midi_packet_assembler.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/midi_packet_assembler.sv
`default_nettype none
// ============================================================================
// Module      : midi_packet_assembler
// Description : Turns a stream of received MIDI bytes into complete channel
//               messages (status + data bytes), with running status support.
// Revision    : 1.0 - initial release
// ============================================================================
module midi_packet_assembler #(
    parameter int BYTE_W      = 8,
    parameter bit VEL0_TO_OFF = 1'b1
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [BYTE_W-1:0] rx_byte,
    input  logic              rx_valid,
    output logic [BYTE_W-1:0] MIDI_CMD,
    output logic [BYTE_W-1:0] MIDI_DAT_0,
    output logic [BYTE_W-1:0] MIDI_DAT_1,
    output logic              MIDI_PACKET_RDY,
    output logic              parse_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_D0 = 2'd1,
        WAIT_D1 = 2'd2,
        SKIP    = 2'd3
    } state_t;

    localparam logic [BYTE_W-1:0] C_STATUS_MIN = BYTE_W'(8'h80);
    localparam logic [BYTE_W-1:0] C_COMMON_MIN = BYTE_W'(8'hF0);
    localparam logic [BYTE_W-1:0] C_RT_MIN     = BYTE_W'(8'hF8);
    localparam logic [BYTE_W-1:0] C_ON_TO_OFF  = BYTE_W'(8'h10);

    state_t              r_state_q, w_state_d;
    logic [BYTE_W-1:0]   r_rs_byte_q, w_rs_byte_d;
    logic                r_rs_valid_q, w_rs_valid_d;
    logic [BYTE_W-1:0]   r_d0_q, w_d0_d;
    logic [BYTE_W-1:0]   r_cmd_q, w_cmd_d;
    logic [BYTE_W-1:0]   r_dat0_q, w_dat0_d;
    logic [BYTE_W-1:0]   r_dat1_q, w_dat1_d;
    logic                r_rdy_q, w_rdy_d;
    logic                r_err_q, w_err_d;
    logic                r_pend_valid_q, w_pend_valid_d;
    logic [BYTE_W-1:0]   r_pend_cmd_q, w_pend_cmd_d;
    logic [BYTE_W-1:0]   r_pend_d0_q, w_pend_d0_d;
    logic [BYTE_W-1:0]   r_pend_d1_q, w_pend_d1_d;

    logic                w_is_data;
    logic                w_is_chan;
    logic                w_is_common;
    logic                w_rs_two;
    logic                w_done;
    logic [BYTE_W-1:0]   w_done_cmd;
    logic [BYTE_W-1:0]   w_done_d0;
    logic [BYTE_W-1:0]   w_done_d1;

    assign w_is_data   = (rx_byte < C_STATUS_MIN);
    assign w_is_chan   = !w_is_data && (rx_byte < C_COMMON_MIN);
    assign w_is_common = (rx_byte >= C_COMMON_MIN) && (rx_byte < C_RT_MIN);
    assign w_rs_two    = !((r_rs_byte_q[7:4] == 4'hC) || (r_rs_byte_q[7:4] == 4'hD));

    // Message parser: tracks position within the current channel message
    always_comb begin
        w_state_d    = r_state_q;
        w_rs_byte_d  = r_rs_byte_q;
        w_rs_valid_d = r_rs_valid_q;
        w_d0_d       = r_d0_q;
        w_err_d      = 1'b0;
        w_done       = 1'b0;
        w_done_d0    = '0;
        w_done_d1    = '0;
        if (rx_valid) begin
            if (w_is_chan) begin
                w_err_d      = (r_state_q == WAIT_D0) || (r_state_q == WAIT_D1);
                w_rs_byte_d  = rx_byte;
                w_rs_valid_d = 1'b1;
                w_state_d    = WAIT_D0;
            end else if (w_is_common) begin
                w_rs_valid_d = 1'b0;
                w_state_d    = SKIP;
            end else if (w_is_data) begin
                case (r_state_q)
                    IDLE, WAIT_D0: begin
                        if ((r_state_q == WAIT_D0) || r_rs_valid_q) begin
                            if (w_rs_two) begin
                                w_d0_d    = rx_byte;
                                w_state_d = WAIT_D1;
                            end else begin
                                w_done    = 1'b1;
                                w_done_d0 = rx_byte;
                                w_state_d = IDLE;
                            end
                        end
                    end
                    WAIT_D1: begin
                        w_done    = 1'b1;
                        w_done_d0 = r_d0_q;
                        w_done_d1 = rx_byte;
                        w_state_d = IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign w_done_cmd = (VEL0_TO_OFF && (r_rs_byte_q[7:4] == 4'h9) && (w_done_d1 == '0))
                        ? (r_rs_byte_q & ~C_ON_TO_OFF) : r_rs_byte_q;

    // A completion landing right after a pulse is parked one cycle so RDY never repeats
    always_comb begin
        w_cmd_d        = r_cmd_q;
        w_dat0_d       = r_dat0_q;
        w_dat1_d       = r_dat1_q;
        w_rdy_d        = 1'b0;
        w_pend_valid_d = r_pend_valid_q;
        w_pend_cmd_d   = r_pend_cmd_q;
        w_pend_d0_d    = r_pend_d0_q;
        w_pend_d1_d    = r_pend_d1_q;
        if (!r_rdy_q && r_pend_valid_q) begin
            w_cmd_d        = r_pend_cmd_q;
            w_dat0_d       = r_pend_d0_q;
            w_dat1_d       = r_pend_d1_q;
            w_rdy_d        = 1'b1;
            w_pend_valid_d = 1'b0;
        end else if (!r_rdy_q && w_done) begin
            w_cmd_d  = w_done_cmd;
            w_dat0_d = w_done_d0;
            w_dat1_d = w_done_d1;
            w_rdy_d  = 1'b1;
        end
        if (w_done && (r_rdy_q || r_pend_valid_q)) begin
            w_pend_valid_d = 1'b1;
            w_pend_cmd_d   = w_done_cmd;
            w_pend_d0_d    = w_done_d0;
            w_pend_d1_d    = w_done_d1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state_q      <= IDLE;
            r_rs_byte_q    <= '0;
            r_rs_valid_q   <= 1'b0;
            r_d0_q         <= '0;
            r_cmd_q        <= '0;
            r_dat0_q       <= '0;
            r_dat1_q       <= '0;
            r_rdy_q        <= 1'b0;
            r_err_q        <= 1'b0;
            r_pend_valid_q <= 1'b0;
            r_pend_cmd_q   <= '0;
            r_pend_d0_q    <= '0;
            r_pend_d1_q    <= '0;
        end else begin
            r_state_q      <= w_state_d;
            r_rs_byte_q    <= w_rs_byte_d;
            r_rs_valid_q   <= w_rs_valid_d;
            r_d0_q         <= w_d0_d;
            r_cmd_q        <= w_cmd_d;
            r_dat0_q       <= w_dat0_d;
            r_dat1_q       <= w_dat1_d;
            r_rdy_q        <= w_rdy_d;
            r_err_q        <= w_err_d;
            r_pend_valid_q <= w_pend_valid_d;
            r_pend_cmd_q   <= w_pend_cmd_d;
            r_pend_d0_q    <= w_pend_d0_d;
            r_pend_d1_q    <= w_pend_d1_d;
        end
    end

    assign MIDI_CMD        = r_cmd_q;
    assign MIDI_DAT_0      = r_dat0_q;
    assign MIDI_DAT_1      = r_dat1_q;
    assign MIDI_PACKET_RDY = r_rdy_q;
    assign parse_err       = r_err_q;

endmodule
`default_nettype wire

// File: tb/tb_midi_packet_assembler.sv
`default_nettype none
// ============================================================================
// Module      : tb_midi_packet_assembler
// Description : Directed and random byte streams checked against a queue-based
//               model of MIDI message assembly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_midi_packet_assembler;

    localparam int BW = 8;
    localparam bit VEL0 = 1'b1;

    logic          sys_clk = 1'b0;
    logic          sys_rst;
    logic [BW-1:0] rx_byte;
    logic          rx_valid;
    logic [BW-1:0] MIDI_CMD;
    logic [BW-1:0] MIDI_DAT_0;
    logic [BW-1:0] MIDI_DAT_1;
    logic          MIDI_PACKET_RDY;
    logic          parse_err;

    midi_packet_assembler #(.BYTE_W(BW), .VEL0_TO_OFF(VEL0)) dut (
        .sys_clk         (sys_clk),
        .sys_rst         (sys_rst),
        .rx_byte         (rx_byte),
        .rx_valid        (rx_valid),
        .MIDI_CMD        (MIDI_CMD),
        .MIDI_DAT_0      (MIDI_DAT_0),
        .MIDI_DAT_1      (MIDI_DAT_1),
        .MIDI_PACKET_RDY (MIDI_PACKET_RDY),
        .parse_err       (parse_err)
    );

    always #5 sys_clk = ~sys_clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: running status plus a queue of collected data bytes
    bit         m_rs_valid;
    logic [7:0] m_rs;
    bit         m_skip;
    bit         m_active;
    logic [7:0] m_q[$];
    logic [7:0] e_cmd, e_d0, e_d1;
    bit         e_rdy, e_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_rs_valid = 0;
        m_rs       = 8'h00;
        m_skip     = 0;
        m_active   = 0;
        m_q.delete();
        e_cmd = 8'h00; e_d0 = 8'h00; e_d1 = 8'h00;
        e_rdy = 0; e_err = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        int need;
        e_rdy = 0;
        e_err = 0;
        if (b >= 8'hF8) begin
        end else if (b >= 8'hF0) begin
            m_rs_valid = 0; m_skip = 1; m_active = 0; m_q.delete();
        end else if (b >= 8'h80) begin
            e_err = m_active;
            m_rs = b; m_rs_valid = 1; m_skip = 0; m_active = 1; m_q.delete();
        end else if (!m_skip && (m_active || m_rs_valid)) begin
            m_active = 1;
            m_q.push_back(b);
            need = (m_rs[7:4] == 4'hC || m_rs[7:4] == 4'hD) ? 1 : 2;
            if (m_q.size() == need) begin
                e_rdy = 1;
                e_cmd = m_rs;
                e_d0  = m_q[0];
                e_d1  = (need == 2) ? m_q[1] : 8'h00;
                if (VEL0 && m_rs[7:4] == 4'h9 && e_d1 == 8'h00) e_cmd = m_rs - 8'h10;
                m_active = 0;
                m_q.delete();
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_rdy"}, MIDI_PACKET_RDY, e_rdy);
        chk({tag, "_err"}, parse_err, e_err);
        chk({tag, "_cmd"}, MIDI_CMD, e_cmd);
        chk({tag, "_d0"},  MIDI_DAT_0, e_d0);
        chk({tag, "_d1"},  MIDI_DAT_1, e_d1);
    endtask

    task automatic send(input logic [7:0] b, input string tag);
        @(negedge sys_clk);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(negedge sys_clk);
        rx_valid = 1'b0;
        rx_byte  = 8'($urandom);
        model_byte(b);
        check_outputs(tag);
        @(negedge sys_clk);
        chk({tag, "_gap_rdy"}, MIDI_PACKET_RDY, 0);
        chk({tag, "_gap_err"}, parse_err, 0);
    endtask

    task automatic expect_pkt(input string tag, input logic [7:0] c, input logic [7:0] d0,
                              input logic [7:0] d1);
        chk({tag, "_cmd"}, MIDI_CMD, c);
        chk({tag, "_d0"},  MIDI_DAT_0, d0);
        chk({tag, "_d1"},  MIDI_DAT_1, d1);
    endtask

    task automatic do_reset(input bit with_valid);
        @(negedge sys_clk);
        sys_rst  = 1'b1;
        rx_valid = with_valid;
        rx_byte  = 8'($urandom_range(0, 127));
        @(negedge sys_clk);
        sys_rst  = 1'b0;
        rx_valid = 1'b0;
        model_reset();
        check_outputs("reset");
    endtask

    initial begin
        logic [7:0] b;
        int r;
        sys_rst  = 1'b1;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        model_reset();
        check_outputs("por");

        send(8'h90, "n_st"); send(8'h3C, "n_d0"); send(8'h64, "n_d1");
        expect_pkt("note_on", 8'h90, 8'h3C, 8'h64);

        send(8'h91, "rs_st"); send(8'h40, "rs_a0"); send(8'h50, "rs_a1");
        expect_pkt("rs_first", 8'h91, 8'h40, 8'h50);
        send(8'h41, "rs_b0"); send(8'h51, "rs_b1");
        expect_pkt("rs_second", 8'h91, 8'h41, 8'h51);

        send(8'h92, "v0_st"); send(8'h3C, "v0_d0"); send(8'hF8, "v0_rt"); send(8'h00, "v0_d1");
        expect_pkt("vel0_off", 8'h82, 8'h3C, 8'h00);

        send(8'hC3, "pc_st"); send(8'h05, "pc_a");
        expect_pkt("prog_a", 8'hC3, 8'h05, 8'h00);
        send(8'h06, "pc_b");
        expect_pkt("prog_b", 8'hC3, 8'h06, 8'h00);

        send(8'hF0, "sx_f0"); send(8'h7E, "sx_7e"); send(8'h01, "sx_01");
        send(8'hF7, "sx_f7"); send(8'h3C, "sx_3c"); send(8'h40, "sx_40");
        expect_pkt("sysex_hold", 8'hC3, 8'h06, 8'h00);

        send(8'h90, "ab_st"); send(8'h3C, "ab_d0"); send(8'h80, "ab_new");
        chk("abort_err_model", e_err, 1);
        send(8'h3C, "ab_n0"); send(8'h00, "ab_n1");
        expect_pkt("abort_off", 8'h80, 8'h3C, 8'h00);

        send(8'h90, "rm_st"); send(8'h3C, "rm_d0");
        do_reset(1'b1);
        send(8'h40, "rm_lone");
        expect_pkt("reset_mid", 8'h00, 8'h00, 8'h00);

        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 99);
            if (r < 50)      b = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 127));
            else if (r < 75) b = 8'($urandom_range(8'h80, 8'hEF));
            else if (r < 85) b = 8'($urandom_range(8'hF0, 8'hF7));
            else             b = 8'($urandom_range(8'hF8, 8'hFF));
            if ($urandom_range(0, 99) < 3) do_reset(1'($urandom));
            send(b, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
